// File: rtl/imm_pkg.sv
// Shared opcode constants and format codes for the
// immediate-generation stage.
package imm_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational format classifier and immediate extractor.
// Ports: instr in; imm (XLEN), fmt, illegal out.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter bit EN_UJ = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [6:0]  opc;
    logic [31:0] v;
    logic        is_i;
    logic        is_s;
    logic        is_b;
    logic        is_u;
    logic        is_j;
    logic        is_r;

    assign opc  = instr[6:0];
    assign is_i = (opc == OPC_LOAD) || (opc == OPC_OPIMM)
               || (opc == OPC_OPIMM32) || (opc == OPC_JALR);
    assign is_s = (opc == OPC_STORE);
    assign is_b = (opc == OPC_BRANCH);
    assign is_u = EN_UJ
               && ((opc == OPC_LUI) || (opc == OPC_AUIPC));
    assign is_j = EN_UJ && (opc == OPC_JAL);
    assign is_r = (opc == OPC_OP) || (opc == OPC_OP32);

    // Build a 32-bit sign-extended value, then widen it.
    always_comb begin
        v       = '0;
        fmt     = FMT_NONE;
        illegal = 1'b1;
        unique case (1'b1)
            is_i: begin
                v = {{20{instr[31]}}, instr[31:20]};
                fmt = FMT_I;
                illegal = 1'b0;
            end
            is_s: begin
                v = {{20{instr[31]}}, instr[31:25],
                     instr[11:7]};
                fmt = FMT_S;
                illegal = 1'b0;
            end
            is_b: begin
                v = {{19{instr[31]}}, instr[31], instr[7],
                     instr[30:25], instr[11:8], 1'b0};
                fmt = FMT_B;
                illegal = 1'b0;
            end
            is_u: begin
                v = {instr[31:12], 12'b0};
                fmt = FMT_U;
                illegal = 1'b0;
            end
            is_j: begin
                v = {{11{instr[31]}}, instr[31],
                     instr[19:12], instr[20],
                     instr[30:21], 1'b0};
                fmt = FMT_J;
                illegal = 1'b0;
            end
            is_r: begin
                fmt = FMT_R;
                illegal = 1'b0;
            end
            default: ;
        endcase
    end

    assign imm = XLEN'($signed(v));

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation stage: decode at the input, 2-entry skid
// buffer at the output.
// Ports: clk, reset (sync, high), flush; in_valid/in_ready/
// in_instr; out_valid/out_ready/out_instr/out_imm/out_fmt/
// out_illegal.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter bit EN_UJ = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output fmt_e            out_fmt,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;

    imm_decode #(
        .XLEN  (XLEN),
        .EN_UJ (EN_UJ)
    ) u_dec (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    logic            main_v, main_v_n;
    logic [31:0]     main_instr, main_instr_n;
    logic [XLEN-1:0] main_imm, main_imm_n;
    fmt_e            main_fmt, main_fmt_n;
    logic            main_ill, main_ill_n;

    logic            skid_v, skid_v_n;
    logic [31:0]     skid_instr, skid_instr_n;
    logic [XLEN-1:0] skid_imm, skid_imm_n;
    fmt_e            skid_fmt, skid_fmt_n;
    logic            skid_ill, skid_ill_n;

    logic            rdy_q;
    logic            acc;
    logic            dlv;

    // rdy_q resets to 1 so in_ready rises the cycle after reset.
    assign in_ready    = rdy_q && !reset;
    assign acc         = in_valid && in_ready;
    assign dlv         = main_v && out_ready;

    assign out_valid   = main_v;
    assign out_instr   = main_instr;
    assign out_imm     = main_imm;
    assign out_fmt     = main_fmt;
    assign out_illegal = main_ill;

    always_comb begin
        main_v_n     = main_v;
        main_instr_n = main_instr;
        main_imm_n   = main_imm;
        main_fmt_n   = main_fmt;
        main_ill_n   = main_ill;
        skid_v_n     = skid_v;
        skid_instr_n = skid_instr;
        skid_imm_n   = skid_imm;
        skid_fmt_n   = skid_fmt;
        skid_ill_n   = skid_ill;

        if (dlv) begin
            main_v_n = 1'b0;
        end

        // A full skid implies in_ready was low: no accept here.
        if (dlv && skid_v) begin
            main_v_n     = 1'b1;
            main_instr_n = skid_instr;
            main_imm_n   = skid_imm;
            main_fmt_n   = skid_fmt;
            main_ill_n   = skid_ill;
            skid_v_n     = 1'b0;
        end else if (acc && (!main_v || dlv)) begin
            main_v_n     = 1'b1;
            main_instr_n = in_instr;
            main_imm_n   = dec_imm;
            main_fmt_n   = dec_fmt;
            main_ill_n   = dec_ill;
        end else if (acc) begin
            skid_v_n     = 1'b1;
            skid_instr_n = in_instr;
            skid_imm_n   = dec_imm;
            skid_fmt_n   = dec_fmt;
            skid_ill_n   = dec_ill;
        end

        if (flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_v     <= 1'b0;
            main_instr <= '0;
            main_imm   <= '0;
            main_fmt   <= FMT_NONE;
            main_ill   <= 1'b0;
            skid_v     <= 1'b0;
            skid_instr <= '0;
            skid_imm   <= '0;
            skid_fmt   <= FMT_NONE;
            skid_ill   <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            main_v     <= main_v_n;
            main_instr <= main_instr_n;
            main_imm   <= main_imm_n;
            main_fmt   <= main_fmt_n;
            main_ill   <= main_ill_n;
            skid_v     <= skid_v_n;
            skid_instr <= skid_instr_n;
            skid_imm   <= skid_imm_n;
            skid_fmt   <= skid_fmt_n;
            skid_ill   <= skid_ill_n;
            rdy_q      <= !skid_v_n;
        end
    end

endmodule
